// File: rtl/user_la_mailbox_pkg.sv
// Package for user_la_mailbox: opcode and state enums, logic-analyzer bit
// positions for the request/response fields, and the constant words the
// responder returns.
//
// Build macro: USER_LA_MAILBOX_SYNC_EN is consumed by user_la_mailbox_sync;
// nothing in this package changes with it.
package user_la_mailbox_pkg;

    typedef enum logic [2:0] {
        OP_ECHO       = 3'd0,
        OP_INVERT     = 3'd1,
        OP_ADD        = 3'd2,
        OP_ACC_CLR    = 3'd3,
        OP_COUNT      = 3'd4,
        OP_SWAP16     = 3'd5,
        OP_CLR_STATUS = 3'd6,
        OP_ILLEGAL    = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Probe side (management -> user project)
    localparam int LA_OPERAND_LO = 0;
    localparam int LA_OPERAND_HI = 31;
    localparam int LA_REQ        = 32;
    localparam int LA_OPCODE_LO  = 33;
    localparam int LA_OPCODE_HI  = 35;

    // Response side (user project -> management)
    localparam int LA_RESULT_LO  = 64;
    localparam int LA_RESULT_HI  = 95;
    localparam int LA_ACK        = 96;
    localparam int LA_BUSY       = 97;
    localparam int LA_ERR        = 98;
    localparam int LA_OVERRUN    = 99;
    localparam int LA_COUNT_LO   = 104;
    localparam int LA_COUNT_HI   = 111;
    localparam int LA_SIG_LO     = 112;
    localparam int LA_SIG_HI     = 127;

    localparam logic [15:0] SIGNATURE = 16'hA5C3;
    localparam logic [31:0] ERR_WORD  = 32'hDEADBEEF;

    function automatic logic [31:0] swap16(input logic [31:0] value);
        return {value[15:0], value[31:16]};
    endfunction

endpackage

// File: rtl/user_la_mailbox_sync.sv
// Request-toggle input stage for user_la_mailbox.
//
// Build macro: USER_LA_MAILBOX_SYNC_EN
//   defined   -> 2-flop synchronizer, for drivers asynchronous to i_clk
//   undefined -> single register stage
//
// Ports:
//   i_clk    clock
//   i_rst    asynchronous active-high reset, clears the stage to 0
//   i_req    raw request toggle from the LA probes
//   o_req_q  registered request toggle
module user_la_mailbox_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    output logic o_req_q
);

`ifdef USER_LA_MAILBOX_SYNC_EN
    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_req;
            r_sync <= r_meta;
        end
    end

    assign o_req_q = r_sync;
`else
    logic r_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req <= 1'b0;
        end else begin
            r_req <= i_req;
        end
    end

    assign o_req_q = r_req;
`endif

endmodule

// File: rtl/user_la_mailbox.sv
// LA mailbox responder: management posts operand/opcode on the LA probes and
// flips a request toggle; this block executes the operation and returns a
// result plus status, then flips the acknowledge toggle.
//
// Build macro: USER_LA_MAILBOX_SYNC_EN adds a second synchronizer flop on the
// request toggle (one extra cycle of ack latency).
//
// Ports:
//   wb_clk_i     clock for all state
//   wb_rst_i     asynchronous active-high reset
//   la_data_in   [31:0] operand, [32] req toggle, [35:33] opcode
//   la_data_out  [95:64] result, [96] ack, [97] busy, [98] err,
//                [99] overrun, [111:104] txn count, [127:112] signature;
//                each bit is 1'bz unless its la_oenb bit is 1
//   la_oenb      per-bit output enable (1 = drive)
//
// state | meaning
// IDLE  | waiting for req_q != req_seen; capture operand/opcode on exit
// EXEC  | compute result, update acc/err
// RESP  | toggle ack, bump transaction count
module user_la_mailbox
    import user_la_mailbox_pkg::*;
(
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [127:0] la_data_in,
    output wire  [127:0] la_data_out,
    input  logic [127:0] la_oenb
);

    state_e      r_state;
    state_e      w_state_nxt;

    logic        w_req_q;
    logic        r_req_seen;
    logic        r_req_prev;
    logic [31:0] r_operand;
    opcode_e     r_opcode;
    logic [31:0] r_result;
    logic [31:0] r_acc;
    logic [7:0]  r_count;
    logic        r_ack;
    logic        r_err;
    logic        r_overrun;

    logic        w_req_pending;
    logic        w_capture;
    logic        w_exec;
    logic        w_resp;
    logic        w_busy;
    logic        w_overrun_set;
    logic [31:0] w_acc_sum;
    logic [127:0] w_int_out;
    logic        w_unused_la;

    assign w_unused_la = ^la_data_in[127:36];

    user_la_mailbox_sync u_sync (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_req   (la_data_in[LA_REQ]),
        .o_req_q (w_req_q)
    );

    assign w_req_pending = (w_req_q != r_req_seen);

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_pending) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State-decoded controls
    always_comb begin
        w_capture = 1'b0;
        w_exec    = 1'b0;
        w_resp    = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            IDLE: w_capture = w_req_pending;
            EXEC: begin
                w_exec = 1'b1;
                w_busy = 1'b1;
            end
            RESP: begin
                w_resp = 1'b1;
                w_busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_acc_sum = r_acc + r_operand;

    // Any movement of req_q while a transaction is in flight is a protocol
    // violation worth recording, even when two flips cancel out.
    assign w_overrun_set = w_busy && (w_req_q != r_req_prev);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_req_seen <= 1'b0;
            r_req_prev <= 1'b0;
            r_operand  <= '0;
            r_opcode   <= OP_ECHO;
            r_result   <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_req_prev <= w_req_q;

            if (w_capture) begin
                r_req_seen <= w_req_q;
                r_operand  <= la_data_in[LA_OPERAND_HI:LA_OPERAND_LO];
                r_opcode   <= opcode_e'(la_data_in[LA_OPCODE_HI:LA_OPCODE_LO]);
            end

            if (w_exec) begin
                r_err <= (r_opcode == OP_ILLEGAL);
                case (r_opcode)
                    OP_ECHO:       r_result <= r_operand;
                    OP_INVERT:     r_result <= ~r_operand;
                    OP_ADD: begin
                        r_acc    <= w_acc_sum;
                        r_result <= w_acc_sum;
                    end
                    OP_ACC_CLR: begin
                        r_acc    <= '0;
                        r_result <= '0;
                    end
                    OP_COUNT:      r_result <= {24'b0, r_count};
                    OP_SWAP16:     r_result <= swap16(r_operand);
                    OP_CLR_STATUS: r_result <= '0;
                    OP_ILLEGAL:    r_result <= ERR_WORD;
                    default:       r_result <= ERR_WORD;
                endcase
            end

            // A fresh violation outranks a clear landing on the same edge.
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_exec && (r_opcode == OP_CLR_STATUS)) begin
                r_overrun <= 1'b0;
            end

            if (w_resp) begin
                r_ack   <= ~r_ack;
                r_count <= r_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_int_out = '0;
        w_int_out[LA_RESULT_HI:LA_RESULT_LO] = r_result;
        w_int_out[LA_ACK]                    = r_ack;
        w_int_out[LA_BUSY]                   = w_busy;
        w_int_out[LA_ERR]                    = r_err;
        w_int_out[LA_OVERRUN]                = r_overrun;
        w_int_out[LA_COUNT_HI:LA_COUNT_LO]   = r_count;
        w_int_out[LA_SIG_HI:LA_SIG_LO]       = SIGNATURE;
    end

    for (genvar g = 0; g < 128; g++) begin : g_oe
        assign la_data_out[g] = la_oenb[g] ? w_int_out[g] : 1'bz;
    end

endmodule

// File: tb/tb_user_la_mailbox.sv
module tb_user_la_mailbox;

`ifdef USER_LA_MAILBOX_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif
    // Edges from driving the toggle until ack is visible.
    localparam int LAT = SYNC_STAGES + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] la_in = '0;
    logic [127:0] oenb = '1;
    wire  [127:0] la_out;
    logic         req_lvl = 1'b0;

    int checks = 0;
    int failures = 0;

    user_la_mailbox dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .la_data_in  (la_in),
        .la_data_out (la_out),
        .la_oenb     (oenb)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [1:0]  m_pipe;
    logic        m_prevq, m_seen;
    int          m_age;
    logic [31:0] m_result, m_acc, p_result, p_acc;
    logic        m_ack, m_busy, m_err, m_ovr, p_err, p_clr;
    logic [7:0]  m_count;

    task automatic model_reset();
        m_pipe = '0; m_prevq = 0; m_seen = 0; m_age = 0;
        m_result = 0; m_acc = 0; p_result = 0; p_acc = 0;
        m_ack = 0; m_busy = 0; m_err = 0; m_ovr = 0; p_err = 0; p_clr = 0;
        m_count = 0;
    endtask

    // One clock edge; uses the inputs that were present at that edge.
    task automatic model_step();
        logic        reqq, ovr_set;
        logic [31:0] opd;
        logic [2:0]  op;
        reqq = m_pipe[SYNC_STAGES-1];
        ovr_set = (m_age != 0) && (reqq != m_prevq);
        if (m_age == 0) begin
            if (reqq != m_seen) begin
                m_seen = reqq;
                opd = la_in[31:0];
                op = la_in[35:33];
                p_acc = m_acc; p_err = 0; p_clr = 0;
                case (op)
                    3'd0: p_result = opd;
                    3'd1: p_result = ~opd;
                    3'd2: begin p_acc = m_acc + opd; p_result = p_acc; end
                    3'd3: begin p_acc = 0; p_result = 0; end
                    3'd4: p_result = {24'b0, m_count};
                    3'd5: p_result = {opd[15:0], opd[31:16]};
                    3'd6: begin p_result = 0; p_clr = 1; end
                    default: begin p_result = 32'hDEADBEEF; p_err = 1; end
                endcase
                m_age = 1;
            end
        end else if (m_age == 1) begin
            m_result = p_result; m_acc = p_acc; m_err = p_err;
            if (p_clr) m_ovr = 0;
            m_age = 2;
        end else begin
            m_ack = ~m_ack;
            m_count = m_count + 8'd1;
            m_age = 0;
        end
        if (ovr_set) m_ovr = 1;
        m_prevq = reqq;
        m_pipe = {m_pipe[0], la_in[32]};
        m_busy = (m_age != 0);
    endtask

    task automatic check_cycle();
        logic [127:0] exp;
        logic ok;
        exp = '0;
        exp[95:64] = m_result;
        exp[96] = m_ack;
        exp[97] = m_busy;
        exp[98] = m_err;
        exp[99] = m_ovr;
        exp[111:104] = m_count;
        exp[127:112] = 16'hA5C3;
        ok = 1'b1;
        for (int i = 0; i < 128; i++) begin
            if (oenb[i]) ok = ok && (la_out[i] === exp[i]);
            else         ok = ok && (la_out[i] !== 1'b1);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL cycle_compare t=%0t got=%h expected=%h oenb=%h", $time, la_out, exp, oenb);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            #1;
            if (rst) model_reset();
            else     model_step();
            check_cycle();
        end
    end

    // ---------------- literal checks and stimulus ----------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Called at posedge+1; drives at posedge+3; returns at posedge+1 after ack.
    task automatic txn(input string nm, input logic [2:0] op, input logic [31:0] opd,
                       input logic [31:0] exp);
        logic a0;
        int n;
        #2;
        la_in[31:0] = opd;
        la_in[35:33] = op;
        req_lvl = ~req_lvl;
        la_in[32] = req_lvl;
        a0 = la_out[96];
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (la_out[96] !== a0) begin n = k; break; end
        end
        chk({nm, "_latency"}, 64'(n), 64'(LAT));
        chk({nm, "_result"}, {32'h0, la_out[95:64]}, {32'h0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic a0;
        int n;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        chk("reset_upper", la_out[127:64], {16'hA5C3, 8'h00, 4'h0, 4'b0000, 32'h0});
        oenb = '0;
        #1;
        chk("oenb0_driven_ones", 64'($countones(la_out)), 64'd0);
        @(posedge clk); #1;
        oenb = {64{2'b10}};
        @(posedge clk); #1;
        @(posedge clk); #1;
        oenb = '1;

        txn("echo", 3'd0, 32'h12345678, 32'h12345678);
        txn("invert", 3'd1, 32'h12345678, 32'hEDCBA987);
        chk("count_after_two", {56'h0, la_out[111:104]}, 64'd2);
        chk("ack_after_two", {63'h0, la_out[96]}, 64'd0);

        txn("add1", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        txn("add2", 3'd2, 32'h00000002, 32'h00000001);
        txn("acc_clr", 3'd3, 32'h0000BEEF, 32'h00000000);
        txn("count_op", 3'd4, 32'h0, 32'h00000005);

        txn("illegal", 3'd7, 32'h0, 32'hDEADBEEF);
        chk("err_set", {63'h0, la_out[98]}, 64'd1);
        txn("echo_clr_err", 3'd0, 32'h0BADF00D, 32'h0BADF00D);
        chk("err_clear", {63'h0, la_out[98]}, 64'd0);

        // Request followed by two more flips while the first is in flight.
        #2;
        la_in[31:0] = 32'h00000055;
        la_in[35:33] = 3'd0;
        req_lvl = ~req_lvl; la_in[32] = req_lvl;
        a0 = la_out[96];
        @(posedge clk); #3;
        req_lvl = ~req_lvl; la_in[32] = req_lvl;
        @(posedge clk); #3;
        req_lvl = ~req_lvl; la_in[32] = req_lvl;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (la_out[96] !== a0) begin n = k; break; end
        end
        chk("dbl_ack_seen", 64'(n != 0), 64'd1);
        chk("dbl_result", {32'h0, la_out[95:64]}, 64'h55);
        repeat (8) begin @(posedge clk); #1; end
        chk("dbl_no_extra_ack", {63'h0, la_out[96]}, {63'h0, ~a0});
        chk("dbl_overrun", {63'h0, la_out[99]}, 64'd1);
        chk("dbl_count", {56'h0, la_out[111:104]}, 64'd9);
        txn("clr_status", 3'd6, 32'h0, 32'h0);
        chk("overrun_cleared", {63'h0, la_out[99]}, 64'd0);

        // Reset while EXEC is in progress.
        #2;
        la_in[31:0] = 32'h11111111;
        la_in[35:33] = 3'd0;
        req_lvl = ~req_lvl; la_in[32] = req_lvl;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (la_out[97] === 1'b1) begin n = k; break; end
        end
        chk("mid_busy_seen", 64'(n), 64'(SYNC_STAGES + 1));
        #2;
        rst = 1'b1;
        req_lvl = 1'b0; la_in[32] = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_reset_status", {16'h0, la_out[111:64]}, 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_reset_no_ack", {16'h0, la_out[111:64]}, 64'h0);

        for (int i = 0; i < 256; i++) begin
            txn("echo_loop", 3'd0, 32'h01010101 * i ^ 32'hA0000000, 32'h01010101 * i ^ 32'hA0000000);
            if (i == 0) chk("post_reset_count", {56'h0, la_out[111:64+40]}, 64'd1);
        end
        chk("count_wrap", {56'h0, la_out[111:104]}, 64'd0);
        txn("swap16", 3'd5, 32'hAAAA5555, 32'h5555AAAA);
        chk("count_after_wrap", {56'h0, la_out[111:104]}, 64'd1);

        repeat (3) begin @(posedge clk); #1; end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
